// File: rtl/bitwise_stream_unit.sv
// Bitwise logic unit with a valid/ready input, a 2-entry result FIFO and a
// saturating count of consumed results.
module bitwise_stream_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [7:0]       op_count
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_e;

  occ_e             state_q;
  occ_e             state_d;
  entry_t           mem_q [DEPTH];
  entry_t           new_entry;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [CNT_W-1:0] op_count_q;
  logic             push;
  logic             pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy transitions; a simultaneous push and pop leaves it unchanged
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push) state_d = S_ONE;
      S_ONE: begin
        if (push && !pop) begin
          state_d = S_FULL;
        end else if (pop && !push) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL:  if (pop) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  // Handshake and head-entry outputs, decoded from registered state only
  always_comb begin
    in_ready  = (state_q != S_FULL);
    out_valid = (state_q != S_EMPTY);
    out_data  = mem_q[rd_ptr_q].data;
    out_err   = mem_q[rd_ptr_q].err;
    op_count  = op_count_q;
  end

  // Result of the presented operation; illegal opcodes yield zero data, err set
  always_comb begin
    new_entry = '0;
    case (in_op)
      3'b000:  new_entry.data = ~in_x;
      3'b001:  new_entry.data = in_x & in_y;
      3'b010:  new_entry.data = in_x | in_y;
      3'b011:  new_entry.data = in_x ^ in_y;
      3'b100:  new_entry.data = in_x ^ ~in_y;
      default: new_entry.err  = 1'b1;
    endcase
  end

  // FIFO storage and 1-bit wrapping pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= new_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Saturating count of output transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (pop && (op_count_q != CNT_MAX)) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bitwise_stream_unit.sv
// Directed self-checking bench for bitwise_stream_unit (WIDTH=4).
module tb_bitwise_stream_unit;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic [7:0]       op_count;

  int total;
  int bad;

  bitwise_stream_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    in_valid = v;
    in_op    = op;
    in_x     = x;
    in_y     = y;
  endtask

  logic [3:0] exp_seq [5];

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    exp_seq[0] = 4'b1010;
    exp_seq[1] = 4'b0100;
    exp_seq[2] = 4'b1101;
    exp_seq[3] = 4'b1001;
    exp_seq[4] = 4'b0110;

    // Reset state
    #3;
    check("rst_in_ready", 8'(in_ready), 8'd1);
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_out_data", 8'(out_data), 8'd0);
    check("rst_out_err", 8'(out_err), 8'd0);
    check("rst_op_count", op_count, 8'd0);
    step();
    rst_n = 1'b1;
    step();

    // All legal ops back-to-back with out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i), 4'b0101, 4'b1100);
      step();
      check($sformatf("op%0d_valid", i), 8'(out_valid), 8'd1);
      check($sformatf("op%0d_data", i), 8'(out_data), 8'(exp_seq[i]));
      check($sformatf("op%0d_err", i), 8'(out_err), 8'd0);
    end
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    step();
    check("seq_drained", 8'(out_valid), 8'd0);
    check("seq_count", op_count, 8'd5);

    // Bring count to 7, fill the FIFO, then reset between edges
    drive(1'b1, 3'b001, 4'b1111, 4'b1111);
    step();
    step();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    step();
    check("pre_rst_count", op_count, 8'd7);
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 4'b0001, 4'b0010);
    step();
    step();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    check("full_in_ready", 8'(in_ready), 8'd0);
    check("full_head", 8'(out_data), 8'b0011);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 8'(out_valid), 8'd0);
    check("async_op_count", op_count, 8'd0);
    check("async_in_ready", 8'(in_ready), 8'd1);
    check("async_out_data", 8'(out_data), 8'd0);
    // No transfer on an edge held in reset
    drive(1'b1, 3'b011, 4'b1111, 4'b0000);
    step();
    check("rst_edge_no_push", 8'(out_valid), 8'd0);
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    #2 rst_n = 1'b1;
    drive(1'b1, 3'b001, 4'b0011, 4'b0101);
    step();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    check("post_rst_valid", 8'(out_valid), 8'd1);
    check("post_rst_data", 8'(out_data), 8'b0001);
    out_ready = 1'b1;
    step();
    check("post_rst_count", op_count, 8'd1);
    check("post_rst_empty", 8'(out_valid), 8'd0);

    // Illegal opcode
    out_ready = 1'b0;
    drive(1'b1, 3'b110, 4'b1111, 4'b1111);
    step();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    check("ill_data", 8'(out_data), 8'd0);
    check("ill_err", 8'(out_err), 8'd1);
    check("ill_count_before", op_count, 8'd1);
    out_ready = 1'b1;
    step();
    check("ill_count_after", op_count, 8'd2);
    check("ill_empty", 8'(out_valid), 8'd0);

    // Backpressure: three ops offered, two accepted, head held
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 4'b0011, 4'b0101);
    step();
    check("bp_ready1", 8'(in_ready), 8'd1);
    drive(1'b1, 3'b010, 4'b0011, 4'b0101);
    step();
    check("bp_ready2", 8'(in_ready), 8'd0);
    drive(1'b1, 3'b011, 4'b0011, 4'b0101);
    step();
    check("bp_head_held", 8'(out_data), 8'b0001);
    check("bp_still_full", 8'(in_ready), 8'd0);
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    out_ready = 1'b1;
    step();
    check("bp_ready_after_pop", 8'(in_ready), 8'd1);
    check("bp_second", 8'(out_data), 8'b0111);
    step();
    check("bp_drained", 8'(out_valid), 8'd0);
    check("bp_count", op_count, 8'd4);

    // Simultaneous push and pop at occupancy 1
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 4'b0000, 4'b0000);
    step();
    out_ready = 1'b1;
    drive(1'b1, 3'b011, 4'b1010, 4'b0110);
    step();
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    check("sim_valid", 8'(out_valid), 8'd1);
    check("sim_in_ready", 8'(in_ready), 8'd1);
    check("sim_data", 8'(out_data), 8'b1100);
    step();
    check("sim_empty", 8'(out_valid), 8'd0);
    check("sim_count", op_count, 8'd6);

    // Saturation: continuous push/pop
    drive(1'b1, 3'b010, 4'b0001, 4'b0000);
    for (int i = 0; i < 100; i++) step();
    check("sat_mid", op_count, 8'd105);
    for (int i = 0; i < 200; i++) step();
    check("sat_reached", op_count, 8'd255);
    drive(1'b0, 3'b000, 4'b0000, 4'b0000);
    step();
    check("sat_hold", op_count, 8'd255);
    check("sat_empty", 8'(out_valid), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitwise_stream_unit.md
BITWISE_STREAM_UNIT -- requirements
Module: bitwise_stream_unit

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream presents an operation.
REQ-005 Port: in_ready  output  1  unit can accept an operation this cycle.
REQ-006 Port: in_op  input  3  opcode: 000 ~x, 001 x&y, 010 x|y, 011 x^y, 100 x^~y; 101-111 illegal.
REQ-007 Port: in_x  input  WIDTH  operand x.
REQ-008 Port: in_y  input  WIDTH  operand y.
REQ-009 Port: out_valid  output  1  result entry available.
REQ-010 Port: out_ready  input  1  downstream consumes the entry this cycle.
REQ-011 Port: out_data  output  WIDTH  result of the head entry.
REQ-012 Port: out_err  output  1  head entry came from an illegal opcode.
REQ-013 Port: op_count  output  8  number of completed output transfers, saturating.

Function
REQ-014 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-015 Result SHALL be computed bitwise over WIDTH bits from in_x/in_y at input transfer; for op 000 in_y is ignored.
REQ-016 Illegal opcode SHALL store out_data=0 and out_err=1 for that entry; legal opcodes store out_err=0.
REQ-017 Each accepted operation SHALL be written, together with its err bit, into a 2-entry FIFO (data+err per entry).
REQ-018 Latency: an operation accepted at edge N into an empty FIFO SHALL appear with out_valid=1 after edge N (visible from cycle N+1); there is no combinational path from in_* to out_*.
REQ-019 FIFO occupancy SHALL be 0, 1 or 2; in_ready SHALL be 1 when occupancy <2, 0 when occupancy =2 (registered-state function only; it SHALL NOT depend on out_ready).
REQ-020 out_valid SHALL be 1 exactly when occupancy >0; out_data/out_err SHALL reflect the oldest entry.
REQ-021 Simultaneous input and output transfer at occupancy 1 SHALL leave occupancy 1 with the new entry at head after the edge; at occupancy 2 input is blocked by in_ready=0.
REQ-022 Read and write pointers SHALL be 1 bit each and wrap 1->0; order SHALL be strict FIFO.
REQ-023 out_data and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 in_valid when in_ready=0 SHALL be ignored with no state change; out_ready when out_valid=0 SHALL be ignored.
REQ-025 op_count SHALL increment by 1 per output transfer and saturate at 255 (no wrap to 0).
REQ-026 Illegal-opcode entries SHALL count in op_count like legal ones.

Reset
REQ-027 While rst_n=0, immediately and independent of clk: occupancy=0, pointers=0, out_valid=0, out_data=0, out_err=0, op_count=0, in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all FIFO contents; first transfer after rst_n rises SHALL behave as into an empty unit.
REQ-029 Deassertion of rst_n SHALL take effect at the next rising clk; no transfer SHALL occur on an edge where rst_n=0.

Verification
REQ-030 WIDTH=4, x=0101, y=1100, ops 000..100 in sequence, out_ready=1 -> outputs 1010, 0100, 1101, 1001, 0110, each err=0, one cycle after acceptance, op_count=5.
REQ-031 op=110, x=1111, y=1111 -> out_data=0000, out_err=1, op_count increments on consumption.
REQ-032 out_ready=0, three back-to-back in_valid ops -> first two accepted, in_ready=0 from third cycle, head data held stable; out_ready=1 -> drains in order, in_ready returns 1 after first pop.
REQ-033 Occupancy 1, simultaneous push and pop -> occupancy stays 1, next output is the newly pushed result, no loss or duplication.
REQ-034 300 consecutive output transfers -> op_count reaches 255 and stays 255.
REQ-035 FIFO full (2 entries), op_count=7, assert rst_n=0 between edges -> out_valid=0, op_count=0, in_ready=1 immediately; after release a single op x=0011,y=0101,op=001 -> out_data=0001.
